// File: rtl/u712_pkg.sv
// Shared types and constants for the U712 chip-bus register cycle sequencer.
//   state_e   : sequencer states
//   SIZ_*     : 68040 SIZ encodings
//   Q_*_DEF   : default quarter indices for strobe placement within a slot
package u712_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SLOT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int Q_START_DEF     = 1;
  localparam int Q_WSTRB_DEF     = 2;
  localparam int Q_STRB_END_DEF  = 6;
  localparam int Q_LAST_DEF      = 7;

  // Line transfers are run as two-word longs.
  function automatic logic is_long(input logic [1:0] siz);
    return (siz == SIZ_LONG) || (siz == SIZ_LINE);
  endfunction

  // Returns {upper_en, lower_en}. Even byte sits on D15:8 (nUDS).
  function automatic logic [1:0] lane_en(input logic [1:0] siz, input logic a0);
    if (siz == SIZ_BYTE) return a0 ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

endpackage

// File: rtl/u712_cclk_sync.sv
// Synchronises the asynchronous Amiga phase clocks and the DMA request into the
// CLK40m domain and produces single-clock event pulses.
//   clk      : CLK40m
//   rst      : synchronous active-high reset (clears the event pulses only)
//   c1_in    : C1 phase clock, asynchronous
//   c3_in    : C3 phase clock, asynchronous
//   n_dbr_in : Agnus DMA request, active low, asynchronous
//   c1_rise  : one-clock pulse on synchronised C1 rising edge (slot boundary)
//   q_evt    : one-clock pulse on any synchronised C1 or C3 edge (quarter event)
//   n_dbr_s  : synchronised nDBR
module u712_cclk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic c1_in,
  input  logic c3_in,
  input  logic n_dbr_in,
  output logic c1_rise,
  output logic q_evt,
  output logic n_dbr_s
);

  localparam int MSB = SYNC_STAGES - 1;

  logic [MSB:0] c1_sync_q, c1_sync_d;
  logic [MSB:0] c3_sync_q, c3_sync_d;
  logic [MSB:0] dbr_sync_q, dbr_sync_d;
  logic         c1_prev_q, c1_prev_d;
  logic         c3_prev_q, c3_prev_d;
  logic         c1_rise_q, c1_rise_d;
  logic         q_evt_q, q_evt_d;

  always_comb begin
    c1_sync_d  = {c1_sync_q[MSB-1:0], c1_in};
    c3_sync_d  = {c3_sync_q[MSB-1:0], c3_in};
    dbr_sync_d = {dbr_sync_q[MSB-1:0], n_dbr_in};
    c1_prev_d  = c1_sync_q[MSB];
    c3_prev_d  = c3_sync_q[MSB];
    c1_rise_d  = c1_sync_q[MSB] & ~c1_prev_q;
    q_evt_d    = (c1_sync_q[MSB] ^ c1_prev_q) | (c3_sync_q[MSB] ^ c3_prev_q);
  end

  // Synchronisers and edge history keep running through reset so that no
  // false edge is reported when reset is released with C1/C3 high.
  always_ff @(posedge clk) begin
    c1_sync_q  <= c1_sync_d;
    c3_sync_q  <= c3_sync_d;
    dbr_sync_q <= dbr_sync_d;
    c1_prev_q  <= c1_prev_d;
    c3_prev_q  <= c3_prev_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c1_rise_q <= 1'b0;
      q_evt_q   <= 1'b0;
    end else begin
      c1_rise_q <= c1_rise_d;
      q_evt_q   <= q_evt_d;
    end
  end

  assign c1_rise = c1_rise_q;
  assign q_evt   = q_evt_q;
  assign n_dbr_s = dbr_sync_q[MSB];

endmodule

// File: rtl/u712_reg_cycle.sv
// Sequences 68040 register-space accesses onto the Amiga 16-bit chip bus,
// aligned to the C1/C3 quarter clocks and deferring to Agnus DMA.
//   CLK40m, RESET        : clock, synchronous active-high reset
//   C1, C3, nDBR         : asynchronous chip-bus timing and DMA inputs
//   nREGSPACE, RnW, SIZ, A : local-bus request (held until nTA)
//   nAS, nUDS, nLDS, nREGEN, REG_A1 : chip-bus side outputs (registered)
//   nTA, BUSY            : local-bus acknowledge and busy status (registered)
//
// state | meaning
// IDLE  | no access; waiting for nREGSPACE low
// ARM   | request latched; waiting for a C1 rise with the bus free of DMA
// SLOT  | one chip-bus word in progress, QCNT counts quarters from Q0
// ACK   | nTA low for this single clock, then back to IDLE
module u712_reg_cycle
  import u712_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int Q_WSTRB     = Q_WSTRB_DEF,
  parameter int Q_STRB_END  = Q_STRB_END_DEF,
  parameter int Q_LAST      = Q_LAST_DEF
) (
  input  logic       CLK40m,
  input  logic       RESET,
  input  logic       C1,
  input  logic       C3,
  input  logic       nREGSPACE,
  input  logic       RnW,
  input  logic [1:0] SIZ,
  input  logic [1:0] A,
  input  logic       nDBR,
  output logic       nAS,
  output logic       nUDS,
  output logic       nLDS,
  output logic       nREGEN,
  output logic       REG_A1,
  output logic       nTA,
  output logic       BUSY
);

  localparam logic [2:0] Q_START_IDX = 3'(Q_START_DEF);
  localparam logic [2:0] Q_WSTRB_IDX = 3'(Q_WSTRB);
  localparam logic [2:0] Q_END_IDX   = 3'(Q_STRB_END);
  localparam logic [2:0] Q_LAST_IDX  = 3'(Q_LAST);

  logic c1_rise, q_evt, n_dbr_s;

  u712_cclk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (CLK40m),
    .rst      (RESET),
    .c1_in    (C1),
    .c3_in    (C3),
    .n_dbr_in (nDBR),
    .c1_rise  (c1_rise),
    .q_evt    (q_evt),
    .n_dbr_s  (n_dbr_s)
  );

  state_e     state_q, state_d;
  logic [2:0] qcnt_q, qcnt_d;
  logic       rnw_q, rnw_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] a_q, a_d;
  logic       word_q, word_d;
  logic       abort_q, abort_d;
  logic       n_as_q, n_as_d;
  logic       n_uds_q, n_uds_d;
  logic       n_lds_q, n_lds_d;
  logic       n_regen_q, n_regen_d;
  logic       reg_a1_q, reg_a1_d;
  logic       n_ta_q, n_ta_d;
  logic       busy_q, busy_d;

  logic [2:0] q_next;
  logic [1:0] lanes;

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    rnw_d     = rnw_q;
    siz_d     = siz_q;
    a_d       = a_q;
    word_d    = word_q;
    abort_d   = abort_q;
    n_as_d    = n_as_q;
    n_uds_d   = n_uds_q;
    n_lds_d   = n_lds_q;
    n_regen_d = n_regen_q;
    reg_a1_d  = reg_a1_q;
    n_ta_d    = 1'b1;
    busy_d    = busy_q;
    q_next    = qcnt_q + 3'd1;
    lanes     = lane_en(siz_q, a_q[0]);

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (!nREGSPACE) begin
          rnw_d   = RnW;
          siz_d   = SIZ;
          a_d     = A;
          word_d  = 1'b0;
          abort_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (nREGSPACE) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (c1_rise && n_dbr_s) begin
          qcnt_d   = 3'd0;
          reg_a1_d = is_long(siz_q) ? word_q : a_q[1];
          state_d  = ST_SLOT;
        end
      end

      ST_SLOT: begin
        // A withdrawn request still runs the slot to completion so the chip
        // bus never sees a truncated strobe; only the acknowledge is dropped.
        if (nREGSPACE) abort_d = 1'b1;
        if (q_evt) begin
          qcnt_d = q_next;
          if (q_next == Q_START_IDX) begin
            n_as_d    = 1'b0;
            n_regen_d = 1'b0;
            if (rnw_q) begin
              n_uds_d = ~lanes[1];
              n_lds_d = ~lanes[0];
            end
          end
          if (!rnw_q && (q_next == Q_WSTRB_IDX)) begin
            n_uds_d = ~lanes[1];
            n_lds_d = ~lanes[0];
          end
          if (q_next == Q_END_IDX) begin
            n_as_d  = 1'b1;
            n_uds_d = 1'b1;
            n_lds_d = 1'b1;
          end
          if (q_next == Q_LAST_IDX) begin
            n_regen_d = 1'b1;
            if (abort_d) begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else if (is_long(siz_q) && !word_q) begin
              word_d  = 1'b1;
              state_d = ST_ARM;
            end else begin
              n_ta_d  = 1'b0;
              state_d = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK40m) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      qcnt_q    <= 3'd0;
      rnw_q     <= 1'b1;
      siz_q     <= SIZ_WORD;
      a_q       <= 2'b00;
      word_q    <= 1'b0;
      abort_q   <= 1'b0;
      n_as_q    <= 1'b1;
      n_uds_q   <= 1'b1;
      n_lds_q   <= 1'b1;
      n_regen_q <= 1'b1;
      reg_a1_q  <= 1'b0;
      n_ta_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      rnw_q     <= rnw_d;
      siz_q     <= siz_d;
      a_q       <= a_d;
      word_q    <= word_d;
      abort_q   <= abort_d;
      n_as_q    <= n_as_d;
      n_uds_q   <= n_uds_d;
      n_lds_q   <= n_lds_d;
      n_regen_q <= n_regen_d;
      reg_a1_q  <= reg_a1_d;
      n_ta_q    <= n_ta_d;
      busy_q    <= busy_d;
    end
  end

  assign nAS    = n_as_q;
  assign nUDS   = n_uds_q;
  assign nLDS   = n_lds_q;
  assign nREGEN = n_regen_q;
  assign REG_A1 = reg_a1_q;
  assign nTA    = n_ta_q;
  assign BUSY   = busy_q;

endmodule
